// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one data RAM between the CPU port (C) and a debug/loader
// port (D). One access is granted per cycle. C has priority, with two exceptions:
// D is forced through after MAX_WAIT consecutive losses, and D can hold the RAM
// exclusively (LOCK) by raising d_lock on a granted beat.
//
// Read return is tagged: the port that issued a read gets rvalid one cycle later,
// with rdata taken straight from ram_rdata. Outside a return cycle each rdata
// output keeps its last returned value.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata  CPU request; c_gnt, c_stall, c_rvalid, c_rdata
//   d_req/d_we/d_lock/d_addr/d_wdata  debug request; d_gnt, d_rvalid, d_rdata
//   ram_rd/ram_wr/ram_raddr/ram_waddr/ram_wdata, ram_rdata  RAM side
//   stat_c_stall, stat_d_gnt   saturating statistics counters
//
// Optional macro RAM_ARB_STATS_EN: enables the statistics counters. When it is
// undefined the stat ports stay present and read 0.
module ram_arbiter #(
    parameter int AWIDTH   = 8,
    parameter int DWIDTH   = 16,
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [AWIDTH-1:0] c_addr,
    input  logic [DWIDTH-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_stall,
    output logic              c_rvalid,
    output logic [DWIDTH-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [DWIDTH-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DWIDTH-1:0] d_rdata,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [AWIDTH-1:0] ram_raddr,
    output logic [AWIDTH-1:0] ram_waddr,
    output logic [DWIDTH-1:0] ram_wdata,
    input  logic [DWIDTH-1:0] ram_rdata,
    output logic [15:0]       stat_c_stall,
    output logic [15:0]       stat_d_gnt
);

    typedef enum logic {ARB, LOCK} state_t;

    localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              rd_vld;    // a read was accepted last cycle
    logic              rd_own_d;  // ...and it belonged to D
    logic [DWIDTH-1:0] c_hold;
    logic [DWIDTH-1:0] d_hold;
    logic              acc_rd;
    logic              c_ret;
    logic              d_ret;

    // Grants are gated by rst so nothing is accepted while reset is high;
    // that is what keeps a read issued in the reset cycle from returning.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (state == LOCK)
                d_gnt = d_req;
            else if (d_req && wait_cnt == MAX_W)
                d_gnt = 1'b1;
            else if (c_req)
                c_gnt = 1'b1;
            else
                d_gnt = d_req;
        end
    end

    assign c_stall = c_req & ~c_gnt;

    always_comb begin
        ram_wr    = (c_gnt & c_we) | (d_gnt & d_we);
        ram_rd    = (c_gnt & ~c_we) | (d_gnt & ~d_we);
        ram_waddr = '0;
        ram_wdata = '0;
        ram_raddr = '0;
        if (ram_wr) begin
            ram_waddr = c_gnt ? c_addr  : d_addr;
            ram_wdata = c_gnt ? c_wdata : d_wdata;
        end
        if (ram_rd)
            ram_raddr = c_gnt ? c_addr : d_addr;
    end

    assign acc_rd   = ram_rd;
    assign c_ret    = ~rst & rd_vld & ~rd_own_d;
    assign d_ret    = ~rst & rd_vld &  rd_own_d;
    assign c_rvalid = c_ret;
    assign d_rvalid = d_ret;
    assign c_rdata  = rst ? '0 : (c_ret ? ram_rdata : c_hold);
    assign d_rdata  = rst ? '0 : (d_ret ? ram_rdata : d_hold);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            wait_cnt <= '0;
            rd_vld   <= 1'b0;
            rd_own_d <= 1'b0;
            c_hold   <= '0;
            d_hold   <= '0;
        end else begin
            case (state)
                ARB:  if (d_gnt && d_lock) state <= LOCK;
                LOCK: if ((d_gnt && !d_lock) || !d_req) state <= ARB;
                default: state <= ARB;
            endcase

            if (d_req && !d_gnt) begin
                if (wait_cnt != MAX_W) wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            rd_vld   <= acc_rd;
            rd_own_d <= d_gnt;
            if (c_ret) c_hold <= ram_rdata;
            if (d_ret) d_hold <= ram_rdata;
        end
    end

`ifdef RAM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_c_stall <= '0;
            stat_d_gnt   <= '0;
        end else begin
            if (c_stall && stat_c_stall != 16'hFFFF) stat_c_stall <= stat_c_stall + 16'd1;
            if (d_gnt && stat_d_gnt != 16'hFFFF)     stat_d_gnt   <= stat_d_gnt + 16'd1;
        end
    end
`else
    assign stat_c_stall = '0;
    assign stat_d_gnt   = '0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised plus directed bench for ram_arbiter. A behavioural model (lock flag,
// loss counter, shadow memory, pending-read record) predicts every output each
// cycle; directed scenarios add literal expectations.
module tb_ram_arbiter;
    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, d_req, d_we, d_lock;
    logic [7:0]  c_addr, d_addr;
    logic [15:0] c_wdata, d_wdata;
    logic        c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid;
    logic [15:0] c_rdata, d_rdata;
    logic        ram_rd, ram_wr;
    logic [7:0]  ram_raddr, ram_waddr;
    logic [15:0] ram_wdata, ram_rdata;
    logic [15:0] stat_c_stall, stat_d_gnt;

    int n_cmp = 0;
    int n_err = 0;

    ram_arbiter #(.AWIDTH(8), .DWIDTH(16), .MAX_WAIT(MAXW), .WAIT_W(4)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_raddr(ram_raddr), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stat_c_stall(stat_c_stall), .stat_d_gnt(stat_d_gnt)
    );

    always #5 clk = ~clk;

    // RAM environment: acts on whatever the DUT actually drives.
    logic [15:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        ram_rdata = 16'h0;
    end
    always @(posedge clk) begin
        if (ram_wr) mem[ram_waddr] <= ram_wdata;
        if (ram_rd) ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_lock;
    int          m_wait;
    bit          m_pv, m_po;        // pending read valid / owner is D
    logic [15:0] m_pd, m_ch, m_dh;  // pending data, per-port held rdata
    int          m_sc, m_sd;        // stat counters
    logic [15:0] shadow [256];
    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = 16'h0;
        m_lock = 0; m_wait = 0; m_pv = 0; m_po = 0;
        m_pd = 0; m_ch = 0; m_dh = 0; m_sc = 0; m_sd = 0;
    end

    always @(negedge clk) begin
        bit ec, ed, es, ewr, erd, ecv, edv;
        logic [7:0]  ewa, era;
        logic [15:0] ewd, ecd, edd, esc, esd;
        ec = 0; ed = 0;
        if (!rst) begin
            if (m_lock) ed = d_req;
            else if (d_req && m_wait >= MAXW) ed = 1;
            else if (c_req) ec = 1;
            else ed = d_req;
        end
        es  = c_req && !ec;
        ewr = (ec && c_we) || (ed && d_we);
        erd = (ec && !c_we) || (ed && !d_we);
        ewa = ewr ? (ec ? c_addr : d_addr) : 8'h0;
        ewd = ewr ? (ec ? c_wdata : d_wdata) : 16'h0;
        era = erd ? (ec ? c_addr : d_addr) : 8'h0;
        ecv = !rst && m_pv && !m_po;
        edv = !rst && m_pv && m_po;
        ecd = rst ? 16'h0 : (ecv ? m_pd : m_ch);
        edd = rst ? 16'h0 : (edv ? m_pd : m_dh);
`ifdef RAM_ARB_STATS_EN
        esc = 16'(m_sc); esd = 16'(m_sd);
`else
        esc = 16'h0; esd = 16'h0;
`endif
        chk("c_gnt",     32'(c_gnt),     32'(ec));
        chk("d_gnt",     32'(d_gnt),     32'(ed));
        chk("c_stall",   32'(c_stall),   32'(es));
        chk("ram_wr",    32'(ram_wr),    32'(ewr));
        chk("ram_rd",    32'(ram_rd),    32'(erd));
        chk("ram_waddr", 32'(ram_waddr), 32'(ewa));
        chk("ram_wdata", 32'(ram_wdata), 32'(ewd));
        chk("ram_raddr", 32'(ram_raddr), 32'(era));
        chk("c_rvalid",  32'(c_rvalid),  32'(ecv));
        chk("d_rvalid",  32'(d_rvalid),  32'(edv));
        chk("c_rdata",   32'(c_rdata),   32'(ecd));
        chk("d_rdata",   32'(d_rdata),   32'(edd));
        chk("stat_c_stall", 32'(stat_c_stall), 32'(esc));
        chk("stat_d_gnt",   32'(stat_d_gnt),   32'(esd));

        // advance model to next cycle
        if (rst) begin
            m_lock = 0; m_wait = 0; m_pv = 0; m_po = 0;
            m_ch = 0; m_dh = 0; m_sc = 0; m_sd = 0;
        end else begin
            if (ecv) m_ch = m_pd;
            if (edv) m_dh = m_pd;
            m_pv = erd; m_po = ed;
            if (erd) m_pd = shadow[era];
            if (ewr) shadow[ewa] = ewd;
            if (!m_lock && ed && d_lock) m_lock = 1;
            else if (m_lock && ((ed && !d_lock) || !d_req)) m_lock = 0;
            if (d_req && !ed) m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
            else m_wait = 0;
            if (es && m_sc < 16'hFFFF) m_sc++;
            if (ed && m_sd < 16'hFFFF) m_sd++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input bit r, input bit cr, input bit cw, input logic [7:0] ca,
                       input logic [15:0] cd, input bit dr, input bit dw, input bit dl,
                       input logic [7:0] da, input logic [15:0] dd);
        @(posedge clk); #1;
        rst = r; c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dd;
        #2;  // literal checks below sample at posedge+3
    endtask

    task automatic idle(input bit r);
        drv(r, 0, 0, 8'h0, 16'h0, 0, 0, 0, 8'h0, 16'h0);
    endtask

    initial begin
        rst = 1; c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_lock = 0; d_addr = 0; d_wdata = 0;
        idle(1); idle(1);
        chk("rst c_gnt", 32'(c_gnt), 0);
        chk("rst ram_rd", 32'(ram_rd), 0);

        // 1: idle after reset, then C write
        idle(0);
        chk("idle gnt", 32'({c_gnt, d_gnt, c_rvalid, d_rvalid, ram_rd, ram_wr}), 0);
        drv(0, 1, 1, 8'h10, 16'hBEEF, 0, 0, 0, 8'h0, 16'h0);
        chk("wr c_gnt", 32'(c_gnt), 1);
        chk("wr ram_wr", 32'(ram_wr), 1);
        chk("wr ram_waddr", 32'(ram_waddr), 32'h10);
        chk("wr ram_wdata", 32'(ram_wdata), 32'hBEEF);

        // 2: C read back
        drv(0, 1, 0, 8'h10, 16'h0, 0, 0, 0, 8'h0, 16'h0);
        chk("rd ram_rd", 32'(ram_rd), 1);
        idle(0);
        chk("rd c_rvalid", 32'(c_rvalid), 1);
        chk("rd c_rdata", 32'(c_rdata), 32'hBEEF);
        chk("rd d_rvalid", 32'(d_rvalid), 0);

        // 3: both requesting continuously, starting from a clean counter
        idle(1);
        for (int i = 0; i < 18; i++) begin
            drv(0, 1, 0, 8'h10, 16'h0, 1, 0, 0, 8'h20, 16'h0);
            chk("starve d_gnt", 32'(d_gnt), 32'((i == 8 || i == 17) ? 1 : 0));
        end
        idle(0);
`ifdef RAM_ARB_STATS_EN
        chk("stat_d_gnt 18cyc", 32'(stat_d_gnt), 2);
        chk("stat_c_stall 18cyc", 32'(stat_c_stall), 2);
`else
        chk("stat_d_gnt off", 32'(stat_d_gnt), 0);
        chk("stat_c_stall off", 32'(stat_c_stall), 0);
`endif

        // 4: lock sequence; first D beat arrives via the starvation limit
        idle(1);
        for (int i = 0; i < 8; i++) drv(0, 1, 0, 8'h1, 16'h0, 1, 1, 1, 8'h30, 16'h1234);
        for (int b = 1; b <= 4; b++) begin
            drv(0, 1, 0, 8'h1, 16'h0, 1, 1, (b < 4), 8'(8'h30 + b), 16'(b));
            chk("lock d_gnt", 32'(d_gnt), 1);
            chk("lock c_stall", 32'(c_stall), 1);
        end
        drv(0, 1, 0, 8'h1, 16'h0, 0, 0, 0, 8'h0, 16'h0);
        chk("unlock c_gnt", 32'(c_gnt), 1);

        // 5: D read issued in the reset cycle
        drv(1, 0, 0, 8'h0, 16'h0, 1, 0, 0, 8'h31, 16'h0);
        drv(0, 1, 0, 8'h2, 16'h0, 1, 0, 0, 8'h31, 16'h0);
        chk("rst-rd d_rvalid", 32'(d_rvalid), 0);
        chk("rst-rd c_gnt (ARB, wait 0)", 32'(c_gnt), 1);
        idle(0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            drv(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 2) != 0), $urandom_range(0, 1), 8'($urandom_range(0, 7)), 16'($urandom),
                ($urandom_range(0, 2) != 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                8'($urandom_range(0, 7)), 16'($urandom));
        end
        idle(0); idle(0);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
